sram_responder: RTL and testbench



---
 rtl/sram_resp_pkg.sv | 52 +++++
 rtl/sram_bank.sv | 44 ++++
 rtl/sram_responder.sv | 151 +++++++++++++++
 tb/tb_sram_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_resp_pkg.sv
// ----------------------------------------------------------------------------
// sram_resp_pkg: shared region decode, MMIO offsets and byte-merge helper.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sram_resp_pkg;

   localparam logic [11:0] c_OFF_TIMER   = 12'h000;
   localparam logic [11:0] c_OFF_SCRATCH = 12'h004;
   localparam logic [11:0] c_OFF_LED     = 12'h008;
   localparam logic [11:0] c_OFF_ERR     = 12'h00C;

   typedef enum logic [1:0] {
      REG_RAM  = 2'd0,
      REG_MMIO = 2'd1,
      REG_NONE = 2'd2
   } region_e;

   function automatic region_e decode_region(
      input logic [31:0] addr,
      input logic [31:0] ram_base,
      input logic [31:0] ram_bytes,
      input logic [31:0] mmio_base
   );
      region_e r;
      r = REG_NONE;
      // Offset compare stays correct even when the RAM ends at the top of the map.
      if ((addr >= ram_base) && ((addr - ram_base) < ram_bytes)) begin
         r = REG_RAM;
      end else if (addr[31:12] == mmio_base[31:12]) begin
         r = REG_MMIO;
      end
      return r;
   endfunction

   function automatic logic [31:0] merge_bytes(
      input logic [31:0] old_w,
      input logic [31:0] new_w,
      input logic [3:0]  be
   );
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sram_bank.sv
// ----------------------------------------------------------------------------
// sram_bank: WORDS x 32 synchronous RAM, read-only inst port plus read-first
// byte-writable data port, one-cycle latency. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_bank #(
   parameter int WORDS = 16384
) (
   input  logic                     clk,
   input  logic                     inst_en_i,
   input  logic [$clog2(WORDS)-1:0] inst_addr_i,
   output logic [31:0]              inst_rdata_o,
   input  logic                     data_en_i,
   input  logic [3:0]               data_we_i,
   input  logic [$clog2(WORDS)-1:0] data_addr_i,
   input  logic [31:0]              data_wdata_i,
   output logic [31:0]              data_rdata_o
);

   logic [31:0] mem_q [WORDS];
   logic [31:0] inst_rdata_q;
   logic [31:0] data_rdata_q;

   // Reads sample the array before this edge's write lands, giving read-first.
   always_ff @(posedge clk) begin
      if (inst_en_i) begin
         inst_rdata_q <= mem_q[inst_addr_i];
      end
      if (data_en_i) begin
         data_rdata_q <= mem_q[data_addr_i];
         if (data_we_i[0]) mem_q[data_addr_i][7:0]   <= data_wdata_i[7:0];
         if (data_we_i[1]) mem_q[data_addr_i][15:8]  <= data_wdata_i[15:8];
         if (data_we_i[2]) mem_q[data_addr_i][23:16] <= data_wdata_i[23:16];
         if (data_we_i[3]) mem_q[data_addr_i][31:24] <= data_wdata_i[31:24];
      end
   end

   assign inst_rdata_o = inst_rdata_q;
   assign data_rdata_o = data_rdata_q;

endmodule

`default_nettype wire

// File: rtl/sram_responder.sv
// ----------------------------------------------------------------------------
// sram_responder: inst/data SRAM-bus responder with RAM, MMIO registers and a
// saturating error counter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_responder #(
   parameter int          MEM_WORDS = 16384,
   parameter logic [31:0] RAM_BASE  = 32'h1fc0_0000,
   parameter logic [31:0] MMIO_BASE = 32'h1faf_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_en,
   input  logic [3:0]  inst_sram_wen,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   output logic [31:0] err_count
);
   import sram_resp_pkg::*;

   localparam int          c_AW        = $clog2(MEM_WORDS);
   localparam logic [31:0] c_RAM_BYTES = 32'(4 * MEM_WORDS);

   region_e     inst_region;
   region_e     data_region;
   logic        inst_err;
   logic        data_err;
   logic        bank_inst_en;
   logic        bank_data_en;
   logic [3:0]  bank_data_we;
   logic [31:0] bank_inst_rdata;
   logic [31:0] bank_data_rdata;
   logic [11:0] data_off;
   logic [31:0] mmio_rdata;
   logic [31:0] led_word;
   logic [32:0] err_sum;

   logic [31:0] timer_q, timer_d;
   logic [31:0] scratch_q, scratch_d;
   logic [15:0] led_q, led_d;
   logic [31:0] err_count_q, err_count_d;
   logic [31:0] data_hold_q, data_hold_d;
   logic        inst_sel_ram_q, inst_sel_ram_d;
   logic        data_sel_ram_q, data_sel_ram_d;

   logic        unused_inst_wdata;
   assign unused_inst_wdata = ^inst_sram_wdata;

   assign inst_region = decode_region(inst_sram_addr, RAM_BASE, c_RAM_BYTES, MMIO_BASE);
   assign data_region = decode_region(data_sram_addr, RAM_BASE, c_RAM_BYTES, MMIO_BASE);
   assign data_off    = data_sram_addr[11:0];

   assign inst_err = inst_sram_en && ((inst_sram_wen != 4'h0) || (inst_region != REG_RAM));
   assign data_err = data_sram_en && (data_region == REG_NONE);

   assign bank_inst_en = inst_sram_en && (inst_region == REG_RAM);
   assign bank_data_en = data_sram_en && (data_region == REG_RAM);
   assign bank_data_we = bank_data_en ? data_sram_wen : 4'h0;

   sram_bank #(
      .WORDS (MEM_WORDS)
   ) u_bank (
      .clk          (clk),
      .inst_en_i    (bank_inst_en),
      .inst_addr_i  (inst_sram_addr[c_AW+1:2]),
      .inst_rdata_o (bank_inst_rdata),
      .data_en_i    (bank_data_en),
      .data_we_i    (bank_data_we),
      .data_addr_i  (data_sram_addr[c_AW+1:2]),
      .data_wdata_i (data_sram_wdata),
      .data_rdata_o (bank_data_rdata)
   );

   always_comb begin
      mmio_rdata = 32'h0;
      case (data_off)
         c_OFF_TIMER:   mmio_rdata = timer_q;
         c_OFF_SCRATCH: mmio_rdata = scratch_q;
         c_OFF_LED:     mmio_rdata = {16'h0, led_q};
         c_OFF_ERR:     mmio_rdata = err_count_q;
         default:       mmio_rdata = 32'h0;
      endcase
   end

   always_comb begin
      timer_d        = timer_q + 32'd1;
      scratch_d      = scratch_q;
      led_d          = led_q;
      led_word       = merge_bytes({16'h0, led_q}, data_sram_wdata, {2'b00, data_sram_wen[1:0]});
      inst_sel_ram_d = inst_sel_ram_q;
      data_sel_ram_d = data_sel_ram_q;
      data_hold_d    = data_hold_q;

      if (data_sram_en && (data_region == REG_MMIO)) begin
         if (data_off == c_OFF_SCRATCH) begin
            scratch_d = merge_bytes(scratch_q, data_sram_wdata, data_sram_wen);
         end
         if (data_off == c_OFF_LED) begin
            led_d = led_word[15:0];
         end
      end

      // Select and non-RAM read value travel together so rdata holds while en=0.
      if (inst_sram_en) begin
         inst_sel_ram_d = (inst_region == REG_RAM);
      end
      if (data_sram_en) begin
         data_sel_ram_d = (data_region == REG_RAM);
         data_hold_d    = (data_region == REG_MMIO) ? mmio_rdata : 32'h0;
      end

      err_sum     = {1'b0, err_count_q} + {32'h0, inst_err} + {32'h0, data_err};
      err_count_d = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer_q        <= 32'h0;
         scratch_q      <= 32'h0;
         led_q          <= 16'h0;
         err_count_q    <= 32'h0;
         data_hold_q    <= 32'h0;
         inst_sel_ram_q <= 1'b0;
         data_sel_ram_q <= 1'b0;
      end else begin
         timer_q        <= timer_d;
         scratch_q      <= scratch_d;
         led_q          <= led_d;
         err_count_q    <= err_count_d;
         data_hold_q    <= data_hold_d;
         inst_sel_ram_q <= inst_sel_ram_d;
         data_sel_ram_q <= data_sel_ram_d;
      end
   end

   assign inst_sram_rdata = inst_sel_ram_q ? bank_inst_rdata : 32'h0;
   assign data_sram_rdata = data_sel_ram_q ? bank_data_rdata : data_hold_q;
   assign led             = led_q;
   assign err_count       = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_responder.sv
// ----------------------------------------------------------------------------
// tb_sram_responder: directed and randomized scoreboard bench for sram_responder.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sram_responder;

   localparam logic [31:0] c_RAM_BASE  = 32'h1fc0_0000;
   localparam logic [31:0] c_MMIO_BASE = 32'h1faf_0000;
   localparam int          c_WINDOW    = 32;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inst_sram_en = 1'b0;
   logic [3:0]  inst_sram_wen = 4'h0;
   logic [31:0] inst_sram_addr = 32'h0;
   logic [31:0] inst_sram_wdata = 32'h0;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_en = 1'b0;
   logic [3:0]  data_sram_wen = 4'h0;
   logic [31:0] data_sram_addr = 32'h0;
   logic [31:0] data_sram_wdata = 32'h0;
   logic [31:0] data_sram_rdata;
   logic [15:0] led;
   logic [31:0] err_count;

   always #5 clk = ~clk;

   sram_responder dut (
      .clk             (clk),
      .resetn          (resetn),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_wen   (inst_sram_wen),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .led             (led),
      .err_count       (err_count)
   );

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: architectural state straight from the behavioural rules.
   logic [31:0] m_mem [int];
   logic [31:0] m_timer = 32'h0;
   logic [31:0] m_scratch = 32'h0;
   logic [15:0] m_led = 16'h0;
   logic [31:0] m_err = 32'h0;

   typedef struct {
      logic [15:0] led;
      logic [31:0] err;
   } st_t;

   logic [31:0] inst_q [$];
   logic [31:0] data_q [$];
   st_t         st_q [$];

   // 0 = RAM, 1 = MMIO, 2 = out of range
   function automatic int m_region(input logic [31:0] a);
      if (a >= c_RAM_BASE && a < c_RAM_BASE + 32'h0001_0000) return 0;
      if (a[31:12] == c_MMIO_BASE[31:12]) return 1;
      return 2;
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a - c_RAM_BASE) >> 2);
   endfunction

   function automatic logic [31:0] m_rd(input logic [31:0] a);
      if (m_mem.exists(m_idx(a))) return m_mem[m_idx(a)];
      return 32'h0;
   endfunction

   task automatic step(input logic ie, input logic [3:0] iw, input logic [31:0] ia,
                       input logic de, input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] dd);
      int          n_err;
      logic [31:0] iexp, dexp, w;
      logic [32:0] s;
      inst_sram_en = ie;  inst_sram_wen = iw;  inst_sram_addr = ia;  inst_sram_wdata = $urandom;
      data_sram_en = de;  data_sram_wen = dw;  data_sram_addr = da;  data_sram_wdata = dd;
      n_err = 0;
      if (ie) begin
         iexp = (m_region(ia) == 0) ? m_rd(ia) : 32'h0;
         if (m_region(ia) != 0 || iw != 4'h0) n_err++;
         inst_q.push_back(iexp);
      end
      if (de) begin
         dexp = 32'h0;
         if (m_region(da) == 0) begin
            w = m_rd(da);
            dexp = w;
            for (int b = 0; b < 4; b++) if (dw[b]) w[8*b +: 8] = dd[8*b +: 8];
            m_mem[m_idx(da)] = w;
         end else if (m_region(da) == 1) begin
            case (da[11:0])
               12'h000: dexp = m_timer;
               12'h004: dexp = m_scratch;
               12'h008: dexp = {16'h0, m_led};
               12'h00C: dexp = m_err;
               default: dexp = 32'h0;
            endcase
            if (da[11:0] == 12'h004)
               for (int b = 0; b < 4; b++) if (dw[b]) m_scratch[8*b +: 8] = dd[8*b +: 8];
            if (da[11:0] == 12'h008)
               for (int b = 0; b < 2; b++) if (dw[b]) m_led[8*b +: 8] = dd[8*b +: 8];
         end else begin
            n_err++;
         end
         data_q.push_back(dexp);
      end
      s = {1'b0, m_err} + 33'(n_err);
      m_err = (s > 33'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
      m_timer = m_timer + 32'd1;
      st_q.push_back('{m_led, m_err});
      @(negedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   function automatic logic [31:0] rnd_addr(input logic is_data);
      int k;
      logic [31:0] offs [6];
      offs = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h7FC};
      k = $urandom_range(0, 9);
      if (k < 7) return c_RAM_BASE + 32'($urandom_range(0, c_WINDOW - 1) * 4) + 32'($urandom_range(0, 3));
      if (k == 7) return c_MMIO_BASE + (is_data ? offs[$urandom_range(0, 5)] : 32'h0);
      return 32'h8000_0000 | 32'($urandom_range(0, 32'h00FF_FFFF));
   endfunction

   // Monitor: pops expected responses for requests seen at each edge.
   initial begin
      logic        ip, dp, hs;
      logic [31:0] iexp, dexp, ilast, dlast;
      st_t         st;
      ilast = 32'h0; dlast = 32'h0; iexp = 32'h0; dexp = 32'h0;
      forever begin
         @(posedge clk);
         ip = inst_sram_en && resetn;
         dp = data_sram_en && resetn;
         hs = (st_q.size() > 0);
         if (hs) st = st_q.pop_front();
         if (ip) begin
            if (inst_q.size() == 0) begin checks++; $display("FAIL inst_queue: got empty expected entry"); ip = 1'b0; end
            else iexp = inst_q.pop_front();
         end
         if (dp) begin
            if (data_q.size() == 0) begin checks++; $display("FAIL data_queue: got empty expected entry"); dp = 1'b0; end
            else dexp = data_q.pop_front();
         end
         @(negedge clk);
         if (!resetn) begin
            ilast = 32'h0; dlast = 32'h0;
         end else begin
            if (ip) begin check("inst_rdata", inst_sram_rdata, iexp); ilast = iexp; end
            else check("inst_hold", inst_sram_rdata, ilast);
            if (dp) begin check("data_rdata", data_sram_rdata, dexp); dlast = dexp; end
            else check("data_hold", data_sram_rdata, dlast);
            if (hs) begin
               check("led", {16'h0, led}, {16'h0, st.led});
               check("err_count", err_count, st.err);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      resetn = 1'b1;
      check("reset_inst_rdata", inst_sram_rdata, 32'h0);
      check("reset_data_rdata", data_sram_rdata, 32'h0);
      check("reset_led", {16'h0, led}, 32'h0);
      check("reset_err", err_count, 32'h0);

      // Timer sampled at the first edge after release.
      step(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, c_MMIO_BASE, 32'h0);

      for (int w = 0; w < c_WINDOW; w++) begin
         v = (w == 4) ? 32'h1122_3344 : (w == 8) ? 32'h0 : (w == 12) ? 32'h0BAD_F00D : $urandom;
         step(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, c_RAM_BASE + 32'(4 * w), v);
      end

      step(1'b0, 4'h0, 32'h0, 1'b1, 4'b0101, 32'h1fc0_0010, 32'hAABB_CCDD);
      step(1'b0, 4'h0, 32'h0, 1'b1, 4'h0,    32'h1fc0_0010, 32'h0);

      step(1'b1, 4'h0, 32'h1fc0_0020, 1'b1, 4'hF, 32'h1fc0_0020, 32'hDEAD_BEEF);
      step(1'b1, 4'h0, 32'h1fc0_0020, 1'b0, 4'h0, 32'h0, 32'h0);

      step(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, c_MMIO_BASE + 32'h8, 32'h1234_ABCD);
      step(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, c_MMIO_BASE + 32'h8, 32'h0);
      step(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, c_MMIO_BASE + 32'h4, 32'hCAFE_F00D);
      step(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, c_MMIO_BASE + 32'h4, 32'h0);

      step(1'b1, 4'h0, c_MMIO_BASE, 1'b1, 4'h0, 32'h0000_0000, 32'h0);

      step(1'b1, 4'h0, 32'h1fc0_0030, 1'b1, 4'h0, 32'h1fc0_0030, 32'h0);
      idle(5);

      step(1'b1, 4'hF, 32'h1fc0_0030, 1'b0, 4'h0, 32'h0, 32'h0);
      step(1'b1, 4'h0, 32'h1fc0_0030, 1'b1, 4'h0, c_MMIO_BASE + 32'hC, 32'h0);

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0, rnd_addr(1'b0),
              $urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0, rnd_addr(1'b1),
              $urandom);
      end

      force dut.err_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.err_count_q;
      m_err = 32'hFFFF_FFFE;
      step(1'b1, 4'h0, c_MMIO_BASE, 1'b1, 4'h0, 32'h8000_0000, 32'h0);
      step(1'b1, 4'hF, 32'h1fc0_0000, 1'b1, 4'h0, 32'h0000_0040, 32'h0);
      step(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, c_MMIO_BASE + 32'hC, 32'h0);
      idle(3);

      check("inst_q_drained", 32'(inst_q.size()), 32'h0);
      check("data_q_drained", 32'(data_q.size()), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
